fb_line_reader: RTL and testbench

- Display-side reader for the byte-per-pixel framebuffer held in SDRAM.
- Acts as the initiator on one SDRAM byte channel (ch_addr/ch_rd/ch_dout/ch_busy/refresh) and reads pixels in raster order, PIXEL_WIDTH x PIXEL_HEIGHT, from ADDR_BASE upward.
- Buffers the pixels in a small FIFO and presents them as a valid/ready pixel stream tagged with x/y.
- Sits between the sdram controller and the VGA scan-out logic, in the clk_sys domain.

---
 rtl/fb_pkg.sv | 18 +
 rtl/fb_pixel_fifo.sv | 65 ++++++
 rtl/fb_line_reader.sv | 185 ++++++++++++++++++
 tb/tb_fb_line_reader.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer types and constants used by the reader, writer and VGA blocks.
package fb_pkg;

    localparam int SDRAM_ADDR_W     = 25;
    localparam int PIX_W            = 8;
    localparam int DEF_PIXEL_WIDTH  = 640;
    localparam int DEF_PIXEL_HEIGHT = 480;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_HI,
        WAIT_LO,
        CAPTURE,
        GAP
    } rd_state_t;

endpackage

// File: rtl/fb_pixel_fifo.sv
// First-word-fall-through pixel FIFO with occupancy count and synchronous flush.
module fb_pixel_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [PIX_W-1:0]           push_data,
    input  logic                       pop,
    output logic [PIX_W-1:0]           head_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign head_data = mem[rd_ptr];
    assign do_pop    = pop && !empty;
    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/fb_line_reader.sv
// Raster-order framebuffer reader: fetches pixels over one SDRAM byte channel
// and presents them as an x/y-tagged valid/ready pixel stream.
module fb_line_reader
    import fb_pkg::*;
#(
    parameter int                      PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int                      PIXEL_HEIGHT = DEF_PIXEL_HEIGHT,
    parameter logic [SDRAM_ADDR_W-1:0] ADDR_BASE    = 25'h0000000,
    parameter int                      FIFO_DEPTH   = 16,
    parameter int                      BUSY_TIMEOUT = 15
) (
    input  logic                    clk_sys,
    input  logic                    reset_n,
    input  logic                    frame_start,
    output logic [SDRAM_ADDR_W-1:0] ch_addr,
    output logic                    ch_rd,
    input  logic [PIX_W-1:0]        ch_dout,
    input  logic                    ch_busy,
    output logic                    refresh,
    output logic [PIX_W-1:0]        pix_data,
    output logic [9:0]              pix_x,
    output logic [8:0]              pix_y,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic                    line_done,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int TOTAL = PIXEL_WIDTH * PIXEL_HEIGHT;
    // One extra code so rd_idx can hold the end-of-frame value W*H.
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [9:0]       X_LAST    = 10'(PIXEL_WIDTH - 1);
    localparam logic [8:0]       Y_LAST    = 9'(PIXEL_HEIGHT - 1);

    rd_state_t        state;
    rd_state_t        state_d;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_idx_d;
    logic [TMR_W-1:0] busy_tmr;
    logic             discard;
    logic             discard_d;
    logic             issue;
    logic             push;
    logic             timeout_hit;
    logic             in_xfer;
    logic             handshake;
    logic             fifo_empty;
    logic [PIX_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;

    assign in_xfer   = (state == WAIT_HI) || (state == WAIT_LO) || (state == CAPTURE);
    assign pix_valid = !fifo_empty;
    assign pix_data  = fifo_empty ? '0 : fifo_head;
    assign handshake = pix_valid && pix_ready;

    always_comb begin
        state_d     = state;
        rd_idx_d    = rd_idx;
        discard_d   = discard;
        issue       = 1'b0;
        push        = 1'b0;
        timeout_hit = 1'b0;
        refresh     = 1'b0;
        unique case (state)
            IDLE: begin
                refresh = 1'b1;
                if (frame_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // Nothing is in flight here, so one free slot is enough to reserve the capture.
                issue   = !frame_start && (rd_idx < LAST_IDX) && (fifo_count < DEPTH_CNT);
                refresh = !issue;
                if (issue) begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (ch_busy) begin
                    state_d = WAIT_LO;
                end else if (busy_tmr == TMR_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = CAPTURE;
                end
            end
            WAIT_LO: begin
                if (!ch_busy) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                push      = !discard && !frame_start;
                discard_d = 1'b0;
                if (!discard) begin
                    rd_idx_d = rd_idx + IDX_W'(1);
                end
                state_d = GAP;
            end
            GAP: begin
                refresh = 1'b1;
                state_d = ((rd_idx == LAST_IDX) && !frame_start) ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
        if (frame_start) begin
            rd_idx_d = '0;
            if ((state == WAIT_HI) || (state == WAIT_LO)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            rd_idx      <= '0;
            discard     <= 1'b0;
            busy_tmr    <= '0;
            ch_rd       <= 1'b0;
            ch_addr     <= ADDR_BASE;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_d;
            rd_idx   <= rd_idx_d;
            discard  <= discard_d;
            busy_tmr <= (state == WAIT_HI) ? busy_tmr + TMR_W'(1) : '0;
            ch_rd    <= (state_d == WAIT_HI) || (state_d == WAIT_LO) || (state_d == CAPTURE);
            // The address is frozen while a transaction is open, even across a frame restart.
            if (!in_xfer) begin
                ch_addr <= ADDR_BASE + SDRAM_ADDR_W'(rd_idx_d);
            end
            if (frame_start) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pix_x      <= '0;
            pix_y      <= '0;
            line_done  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            line_done  <= handshake && (pix_x == X_LAST);
            frame_done <= handshake && (pix_x == X_LAST) && (pix_y == Y_LAST);
            if (frame_start) begin
                pix_x <= '0;
                pix_y <= '0;
            end else if (handshake) begin
                if (pix_x == X_LAST) begin
                    pix_x <= '0;
                    pix_y <= (pix_y == Y_LAST) ? '0 : pix_y + 9'd1;
                end else begin
                    pix_x <= pix_x + 10'd1;
                end
            end
        end
    end

    fb_pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .flush     (frame_start),
        .push      (push),
        .push_data (ch_dout),
        .pop       (handshake),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fb_line_reader.sv
// Directed bench for fb_line_reader on an 8x4 frame with a simple SDRAM channel model.
module tb_fb_line_reader;
    import fb_pkg::*;

    localparam int          W    = 8;
    localparam int          H    = 4;
    localparam int          NPIX = W * H;
    localparam logic [24:0] BASE = 25'h100;

    logic        clk_sys     = 1'b0;
    logic        reset_n     = 1'b0;
    logic        frame_start = 1'b0;
    logic [24:0] ch_addr;
    logic        ch_rd;
    logic [7:0]  ch_dout;
    logic        ch_busy     = 1'b0;
    logic        refresh;
    logic [7:0]  pix_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_valid;
    logic        pix_ready   = 1'b0;
    logic        line_done;
    logic        frame_done;
    logic        timeout_err;

    int tests_run    = 0;
    int tests_failed = 0;
    bit busy_mode    = 1'b1;
    int mdl_cnt      = 0;

    typedef struct packed {
        logic [7:0] d;
        logic [9:0] x;
        logic [8:0] y;
    } pix_t;

    typedef struct {
        int ready_period;
        bit busy_on;
        int exp_pix;
        int exp_lines;
        int exp_frames;
        bit exp_timeout;
    } vec_t;

    pix_t rx_q[$];
    int   line_cnt  = 0;
    int   frame_cnt = 0;
    int   rd_rises  = 0;
    logic prev_rd   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    assign ch_dout = ch_addr[7:0];

    fb_line_reader #(
        .PIXEL_WIDTH  (W),
        .PIXEL_HEIGHT (H),
        .ADDR_BASE    (BASE),
        .FIFO_DEPTH   (16),
        .BUSY_TIMEOUT (15)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .ch_addr     (ch_addr),
        .ch_rd       (ch_rd),
        .ch_dout     (ch_dout),
        .ch_busy     (ch_busy),
        .refresh     (refresh),
        .pix_data    (pix_data),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    // Controller model: busy goes high about two cycles into a read and stays for three.
    always @(negedge clk_sys) begin
        if (ch_rd) mdl_cnt = mdl_cnt + 1;
        else       mdl_cnt = 0;
        ch_busy = busy_mode && ch_rd && (mdl_cnt >= 3) && (mdl_cnt <= 5);
    end

    always @(negedge clk_sys) begin
        if (reset_n && pix_valid && pix_ready) rx_q.push_back({pix_data, pix_x, pix_y});
        if (line_done)  line_cnt  = line_cnt + 1;
        if (frame_done) frame_cnt = frame_cnt + 1;
        if (ch_rd && !prev_rd) rd_rises = rd_rises + 1;
        prev_rd = ch_rd;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run = tests_run + 1;
        if (actual !== expected) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pulseFrameStart(output int mark);
        @(posedge clk_sys); #1;
        frame_start = 1'b1;
        @(negedge clk_sys); #1;
        mark = rx_q.size();
        @(posedge clk_sys); #1;
        frame_start = 1'b0;
    endtask

    task automatic runPixels(input int mark, input int n, input int period, input int budget);
        int cyc = 0;
        while (((rx_q.size() - mark) < n) && (cyc < budget)) begin
            @(posedge clk_sys); #1;
            pix_ready = ((cyc % period) == 0);
            cyc++;
        end
        pix_ready = 1'b1;
    endtask

    task automatic checkStream(input int mark, input int n, input string name);
        pix_t got;
        pix_t exp;
        for (int i = 0; i < n; i++) begin
            got = (mark + i < rx_q.size()) ? rx_q[mark + i] : '1;
            exp = {8'(i), 10'(i % W), 9'(i / W)};
            checkOutput($sformatf("%s[%0d]", name, i), 32'(got), 32'(exp));
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int mark;
        int l0;
        int f0;
        busy_mode = v.busy_on;
        l0 = line_cnt;
        f0 = frame_cnt;
        pulseFrameStart(mark);
        runPixels(mark, v.exp_pix, v.ready_period, 4000);
        repeat (20) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput($sformatf("vec%0d_count", idx), 32'(rx_q.size() - mark), 32'(v.exp_pix));
        checkStream(mark, v.exp_pix, $sformatf("vec%0d_pix", idx));
        checkOutput($sformatf("vec%0d_lines", idx), 32'(line_cnt - l0), 32'(v.exp_lines));
        checkOutput($sformatf("vec%0d_frames", idx), 32'(frame_cnt - f0), 32'(v.exp_frames));
        checkOutput($sformatf("vec%0d_timeout", idx), 32'(timeout_err), 32'(v.exp_timeout));
        checkOutput($sformatf("vec%0d_idle", idx), {29'd0, refresh, ch_rd, pix_valid}, 32'b100);
    endtask

    initial begin
        vec_t vecs[4];
        int   mark;
        int   mark1;
        int   r0;
        int   cnt;
        bit   hit;

        vecs[0] = '{1, 1'b1, NPIX, H, 1, 1'b0};
        vecs[1] = '{2, 1'b1, NPIX, H, 1, 1'b0};
        vecs[2] = '{5, 1'b1, NPIX, H, 1, 1'b0};
        vecs[3] = '{1, 1'b0, NPIX, H, 1, 1'b1};

        #12;
        checkOutput("rst_addr", 32'(ch_addr), 32'(BASE));
        checkOutput("rst_ctrl", {29'd0, ch_rd, refresh, pix_valid}, 32'b010);
        checkOutput("rst_pix", {5'd0, pix_data, pix_x, pix_y}, 32'd0);
        checkOutput("rst_flags", {29'd0, line_done, frame_done, timeout_err}, 32'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput("idle_no_start", {29'd0, refresh, ch_rd, pix_valid}, 32'b100);

        for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

        // Backpressure: FIFO fills, then a single pop lets exactly one more read through.
        busy_mode = 1'b1;
        pix_ready = 1'b0;
        r0 = rd_rises;
        pulseFrameStart(mark);
        repeat (300) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput("bp_reads", 32'(rd_rises - r0), 32'd16);
        checkOutput("bp_stall", {29'd0, refresh, ch_rd, pix_valid}, 32'b101);
        @(posedge clk_sys); #1;
        pix_ready = 1'b1;
        @(posedge clk_sys); #1;
        pix_ready = 1'b0;
        repeat (40) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput("bp_one_pop", 32'(rx_q.size() - mark), 32'd1);
        checkOutput("bp_reads_after_pop", 32'(rd_rises - r0), 32'd17);
        checkOutput("bp_stall_again", {30'd0, refresh, ch_rd}, 32'b10);
        runPixels(mark, NPIX, 1, 2000);
        repeat (20) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput("bp_count", 32'(rx_q.size() - mark), 32'(NPIX));
        checkStream(mark, NPIX, "bp_pix");

        // Restart during WAIT_LO of address 0x105.
        pix_ready = 1'b1;
        pulseFrameStart(mark);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk_sys); #1;
            hit = ch_rd && (ch_addr == 25'h105) && ch_busy;
        end
        checkOutput("disc_found_105", 32'(hit), 32'd1);
        @(posedge clk_sys); #1;
        frame_start = 1'b1;
        @(negedge clk_sys); #1;
        mark1 = rx_q.size();
        checkOutput("disc_rd_held", 32'(ch_rd), 32'd1);
        @(posedge clk_sys); #1;
        frame_start = 1'b0;
        checkOutput("disc_before_count", 32'(mark1 - mark), 32'd5);
        cnt = 0;
        while (ch_rd && cnt < 50) begin @(negedge clk_sys); #1; cnt++; end
        cnt = 0;
        while (!ch_rd && cnt < 50) begin @(negedge clk_sys); #1; cnt++; end
        checkOutput("disc_restart_rd", 32'(ch_rd), 32'd1);
        checkOutput("disc_restart_addr", 32'(ch_addr), 32'(BASE));
        runPixels(mark1, NPIX, 1, 2000);
        repeat (20) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput("disc_count", 32'(rx_q.size() - mark1), 32'(NPIX));
        checkStream(mark1, NPIX, "disc_pix");

        // Busy never rises: timeout after 15 cycles, then a restart clears the flag.
        busy_mode = 1'b0;
        pulseFrameStart(mark);
        cnt = 0;
        while (!ch_rd && cnt < 50) begin @(negedge clk_sys); #1; cnt++; end
        cnt = 0;
        while (!timeout_err && cnt < 100) begin @(negedge clk_sys); #1; cnt++; end
        checkOutput("to_latency", 32'(cnt), 32'd15);
        busy_mode = 1'b1;
        pulseFrameStart(mark);
        @(negedge clk_sys); #1;
        checkOutput("to_cleared", 32'(timeout_err), 32'd0);
        runPixels(mark, NPIX, 1, 2000);
        repeat (20) @(posedge clk_sys);
        @(negedge clk_sys); #1;
        checkOutput("to_count", 32'(rx_q.size() - mark), 32'(NPIX));
        checkStream(mark, NPIX, "to_pix");

        // Asynchronous reset with five pixels buffered and a read open.
        pix_ready = 1'b0;
        r0 = rd_rises;
        pulseFrameStart(mark);
        hit = 1'b0;
        for (int c = 0; c < 500 && !hit; c++) begin
            @(negedge clk_sys); #1;
            hit = ((rd_rises - r0) >= 6) && ch_rd;
        end
        checkOutput("rst_mid_found", 32'(hit), 32'd1);
        checkOutput("rst_mid_buffered", 32'(pix_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("rst_mid_ctrl", {29'd0, ch_rd, pix_valid, refresh}, 32'b001);
        checkOutput("rst_mid_addr", 32'(ch_addr), 32'(BASE));
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk_sys);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
